// File: rtl/alu_result_collector.sv
// Collects results from a fixed-latency ALU: aligns issue tags with the ALU
// output, buffers them in a small FIFO and returns credit to the issuer.
module alu_result_collector #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic                     clk_p_i,
  input  logic                     reset_p_i,
  input  logic                     issue_valid_i,
  input  logic [2:0]               issue_inst_i,
  output logic                     issue_ready_o,
  input  logic [15:0]              alu_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [15:0]              out_data_o,
  output logic [2:0]               out_inst_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(DEPTH + LATENCY + 1) + 1;

  logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [2:0]         tag_inst_q [LATENCY];
  logic [2:0]         tag_inst_d [LATENCY];
  logic [18:0]        mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               drop_q, drop_d;
  logic [SW-1:0]      inflight, credit_used;
  logic               accept, push, pop;

  // Credit counts both buffered entries and tags still travelling to the ALU output.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < LATENCY; k++) begin
      inflight = inflight + SW'(tag_vld_q[k]);
    end
    credit_used = SW'(count_q) + inflight;
  end

  assign issue_ready_o = credit_used < SW'(DEPTH);
  assign accept        = issue_valid_i & issue_ready_o;
  assign push          = tag_vld_q[LATENCY-1];
  assign out_valid_o   = count_q != '0;
  assign pop           = out_valid_o & out_ready_i;

  // NOTE: every always_comb output gets an assignment on every path, so no latch is inferred.
  always_comb begin
    tag_vld_d[0]  = accept;
    tag_inst_d[0] = issue_inst_i;
    for (int k = 1; k < LATENCY; k++) begin
      tag_vld_d[k]  = tag_vld_q[k-1];
      tag_inst_d[k] = tag_inst_q[k-1];
    end
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    drop_d   = drop_q | (issue_valid_i & ~issue_ready_o);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_p_i or posedge reset_p_i) begin
    if (reset_p_i) begin
      tag_vld_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        tag_inst_q[k] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      tag_vld_q  <= tag_vld_d;
      tag_inst_q <= tag_inst_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
    end
  end

  // NOTE: storage is not reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_p_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {tag_inst_q[LATENCY-1], alu_data_i};
    end
  end

  assign {out_inst_o, out_data_o} = out_valid_o ? mem_q[rd_ptr_q] : 19'd0;
  assign count_o = count_q;
  assign drop_o  = drop_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector: a 2-cycle ALU model feeds results,
// a scoreboard queue holds expected outputs and a monitor compares the head.
module tb_alu_result_collector;

  localparam int DEPTH   = 4;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [2:0]  issue_inst;
  logic        issue_ready;
  logic [15:0] alu_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_inst;
  logic [2:0]  count;
  logic        drop;

  logic [15:0] alu_op_data;
  logic [15:0] alu_p0, alu_p1;
  logic        issue_exp;
  logic        acc_p0, acc_p1;
  logic [18:0] exp_q[$];
  int          n_vec = 0;
  int          n_mis = 0;

  alu_result_collector #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk_p_i      (clk),
    .reset_p_i    (rst),
    .issue_valid_i(issue_valid),
    .issue_inst_i (issue_inst),
    .issue_ready_o(issue_ready),
    .alu_data_i   (alu_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_inst_o   (out_inst),
    .count_o      (count),
    .drop_o       (drop)
  );

  always #5 clk = ~clk;

  // ALU model: result of the operands driven this cycle appears two edges later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_p0 <= 16'h0;
      alu_p1 <= 16'h0;
      acc_p0 <= 1'b0;
      acc_p1 <= 1'b0;
    end else begin
      alu_p0 <= alu_op_data;
      alu_p1 <= alu_p0;
      acc_p0 <= issue_valid & issue_exp;
      acc_p1 <= acc_p0;
    end
  end
  assign alu_data = alu_p1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] inst, input logic [15:0] d, input logic exp_acc);
    issue_valid = 1'b1;
    issue_inst  = inst;
    alu_op_data = d;
    issue_exp   = exp_acc;
    check("issue_ready", 32'(issue_ready), 32'(exp_acc));
    if (exp_acc) exp_q.push_back({inst, d});
    tick();
    issue_valid = 1'b0;
    issue_exp   = 1'b0;
    alu_op_data = 16'hDEAD;
  endtask

  // Monitor: head must always equal the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL unexpected_out: got inst=%0d data=0x%0h, expected no output (t=%0t)",
                   out_inst, out_data, $time);
        end else begin
          check("head", 32'({out_inst, out_data}), 32'(exp_q[0]));
          if (out_ready) exp_q.delete(0);
        end
      end
      if (acc_p1 && !(out_valid && out_ready))
        check("no_overflow", 32'(count < 3'(DEPTH)), 32'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_inst = 3'd0; issue_exp = 1'b0;
    alu_op_data = 16'hDEAD; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_drop",  32'(drop), 32'd0);
    check("rst_ready", 32'(issue_ready), 32'd1);
    check("rst_data",  32'(out_data), 32'd0);
    check("rst_inst",  32'(out_inst), 32'd0);

    // Single op: visible after the second edge following acceptance.
    issue(3'd0, 16'h0008, 1'b1);
    check("lat_e0_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_e1_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_e2_valid", 32'(out_valid), 32'd1);
    check("single_data",  32'(out_data), 32'h0008);
    check("single_inst",  32'(out_inst), 32'd0);
    check("single_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_popped", 32'(count), 32'd0);

    // Back-to-back with consumer always ready.
    out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      issue(3'(n), 16'h0100 + 16'(n), 1'b1);
      check("b2b_count_le2", 32'(count <= 3'd2), 32'd1);
    end
    for (int n = 0; n < 4; n++) begin
      tick();
      check("b2b_count_le2", 32'(count <= 3'd2), 32'd1);
    end
    out_ready = 1'b0;
    check("b2b_empty", 32'(count), 32'd0);
    check("b2b_all_seen", 32'(exp_q.size()), 32'd0);

    // Stall until full; data includes bit15-set values.
    issue(3'd1, 16'hFFFF, 1'b1);
    issue(3'd2, 16'h8001, 1'b1);
    issue(3'd3, 16'h0A03, 1'b1);
    issue(3'd4, 16'h7FFE, 1'b1);
    check("full_ready_low", 32'(issue_ready), 32'd0);
    tick(); tick();
    check("full_count", 32'(count), 32'd4);
    check("full_nodrop", 32'(drop), 32'd0);

    // Drop: issue while not ready is ignored and sticks.
    issue(3'd7, 16'hBEEF, 1'b0);
    check("drop_set", 32'(drop), 32'd1);
    tick(); tick(); tick();
    check("drop_count", 32'(count), 32'd4);
    check("drop_sticky", 32'(drop), 32'd1);

    // Pop-only edge returns credit next cycle; later push+pop keeps count.
    check("pre_pop_ready", 32'(issue_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop_count", 32'(count), 32'd3);
    check("ready_after_pop", 32'(issue_ready), 32'd1);
    issue(3'd5, 16'h0A05, 1'b1);
    check("inflight_ready", 32'(issue_ready), 32'd0);
    check("inflight_count", 32'(count), 32'd3);
    tick();
    check("hold_count", 32'(count), 32'd3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pushpop_count", 32'(count), 32'd3);
    check("pushpop_ready", 32'(issue_ready), 32'd1);
    out_ready = 1'b1;
    tick(); tick(); tick();
    out_ready = 1'b0;
    check("drain_count", 32'(count), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);

    // Reset with 2 entries buffered and 2 in flight.
    for (int n = 0; n < 4; n++) issue(3'(n), 16'h1110 + 16'(n), 1'b1);
    check("mid_count", 32'(count), 32'd2);
    check("mid_ready", 32'(issue_ready), 32'd0);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_drop",  32'(drop), 32'd0);
    check("mid_rst_ready", 32'(issue_ready), 32'd1);
    check("mid_rst_data",  32'(out_data), 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 6; n++) tick();
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_count", 32'(count), 32'd0);
    check("post_rst_ready", 32'(issue_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
